// File: rtl/internoc_ni_axi_slave_lite.sv
// internoc_ni_axi_slave_lite
// AXI4-Lite slave responder for the InterNoC network interface. It terminates
// the AW/W/B and AR/R channels onto a small byte-writable register file and
// returns OKAY/SLVERR responses. The write and read channels run independently.
//
// Optional feature: define NI_SLAVE_ADDR_CHECK_EN to answer out-of-range word
// indices with SLVERR. An out-of-range write then leaves the registers
// unchanged, and an out-of-range read returns zero. When the macro is not
// defined, the word index wraps onto the register file and every response is
// OKAY.

module internoc_ni_axi_slave_lite #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_REGS           = 8
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic                              WR_DONE,
   output logic                              RD_DONE
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = DW / 8;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int FW = AW - 2;                                    // full word-index width
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;     // register-select width

   localparam logic [1:0] W_IDLE      = 2'd0;
   localparam logic [1:0] W_WAIT_DATA = 2'd1;
   localparam logic [1:0] W_WAIT_ADDR = 2'd2;
   localparam logic [1:0] W_RESP      = 2'd3;

   localparam logic R_IDLE = 1'b0;
   localparam logic R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DW-1:0] regs [NUM_REGS];

   logic          live;           // low in reset, high from the first edge after release
   logic [1:0]    w_state;
   logic          r_state;
   logic [FW-1:0] aw_word_q;
   logic [DW-1:0] w_data_q;
   logic [SW-1:0] w_strb_q;
   logic [1:0]    bresp_q;
   logic [DW-1:0] rdata_q;
   logic [1:0]    rresp_q;
   logic          wr_done_q;
   logic          rd_done_q;

   logic          awready;
   logic          wready;
   logic          arready;
   logic          aw_hs;
   logic          w_hs;
   logic          ar_hs;

   logic          commit;
   logic [FW-1:0] c_word;
   logic [DW-1:0] c_data;
   logic [SW-1:0] c_strb;

   logic [IW-1:0] wr_idx;
   logic          wr_ok;
   logic [FW-1:0] rd_word;
   logic [IW-1:0] rd_idx;
   logic          rd_ok;

   // The readies depend only on registered state, so there is no path from any
   // input VALID/READY to an output.
   assign awready = live && (w_state == W_IDLE || w_state == W_WAIT_ADDR);
   assign wready  = live && (w_state == W_IDLE || w_state == W_WAIT_DATA);
   assign arready = live && (r_state == R_IDLE);

   assign aw_hs = S_AXI_AWVALID && awready;
   assign w_hs  = S_AXI_WVALID  && wready;
   assign ar_hs = S_AXI_ARVALID && arready;

   // Select the address, data and strobe of the write that completes this cycle.
   // Each one comes from the bus if its handshake happens now, or from its
   // capture register otherwise.
   always_comb begin
      // NOTE: assign every output of this block a default first, so no path leaves one unassigned and no latch is inferred.
      commit = 1'b0;
      c_word = aw_word_q;
      c_data = w_data_q;
      c_strb = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               c_word = S_AXI_AWADDR[AW-1:2];
               c_data = S_AXI_WDATA;
               c_strb = S_AXI_WSTRB;
            end
         end
         W_WAIT_DATA: begin
            if (w_hs) begin
               commit = 1'b1;
               c_data = S_AXI_WDATA;
               c_strb = S_AXI_WSTRB;
            end
         end
         W_WAIT_ADDR: begin
            if (aw_hs) begin
               commit = 1'b1;
               c_word = S_AXI_AWADDR[AW-1:2];
            end
         end
         default: ;
      endcase
   end

   assign wr_idx  = c_word[IW-1:0];
   assign rd_word = S_AXI_ARADDR[AW-1:2];
   assign rd_idx  = rd_word[IW-1:0];

`ifdef NI_SLAVE_ADDR_CHECK_EN
   assign wr_ok = (int'(c_word)  < NUM_REGS);
   assign rd_ok = (int'(rd_word) < NUM_REGS);
`else
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   // Sink for the protection bits, the byte-lane address bits and any
   // word-index bits above the register select.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                          S_AXI_ARADDR[1:0], c_word, rd_word};

   // The bus is held off until the first edge after reset is released.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) live <= 1'b0;
      else        live <= 1'b1;
   end

   // Register file: byte-masked update at the edge that completes a write.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         // NOTE: the register file must read zero after reset, so it is built from resettable flops, not a RAM macro.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit && wr_ok) begin
         for (int b = 0; b < SW; b++) begin
            if (c_strb[b]) regs[wr_idx][8*b +: 8] <= c_data[8*b +: 8];
         end
      end
   end

   // Write channel: capture AW and W in either order, commit, then hold B until it is accepted.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         // NOTE: sequential state uses non-blocking assignments, so every block sees the values from before the edge.
         w_state   <= W_IDLE;
         aw_word_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= RESP_OKAY;
         wr_done_q <= 1'b0;
      end else begin
         wr_done_q <= commit;
         if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         case (w_state)
            W_IDLE: begin
               if (aw_hs) aw_word_q <= S_AXI_AWADDR[AW-1:2];
               if (w_hs) begin
                  w_data_q <= S_AXI_WDATA;
                  w_strb_q <= S_AXI_WSTRB;
               end
               if (commit)     w_state <= W_RESP;
               else if (aw_hs) w_state <= W_WAIT_DATA;
               else if (w_hs)  w_state <= W_WAIT_ADDR;
            end
            W_WAIT_DATA: if (commit) w_state <= W_RESP;
            W_WAIT_ADDR: if (commit) w_state <= W_RESP;
            W_RESP:      if (S_AXI_BREADY) w_state <= W_IDLE;
            default:     w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel: register the data and response at the AR handshake, then hold them until R is accepted.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state   <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rd_done_q <= 1'b0;
      end else begin
         rd_done_q <= ar_hs;
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state <= R_DATA;
                  rdata_q <= rd_ok ? regs[rd_idx] : '0;
                  rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
               end
            end
            default: if (S_AXI_RREADY) r_state <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready;
   assign S_AXI_WREADY  = wready;
   assign S_AXI_ARREADY = arready;
   assign S_AXI_BVALID  = (w_state == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign WR_DONE       = wr_done_q;
   assign RD_DONE       = rd_done_q;

endmodule
